// File: rtl/context_update_engine_if.sv
// Request, lookup and commit signals of the context update engine, grouped as one bundle.
// Purely wiring: no storage, no latency.
// No backpressure of its own; in_ready is driven by the engine.
interface context_update_engine_if #(
    parameter int BPP       = 8,
    parameter int A_LENGTH  = 14,
    parameter int B_LENGTH  = 8,
    parameter int C_LENGTH  = 8,
    parameter int N_LENGTH  = 7,
    parameter int NN_LENGTH = 7,
    parameter int CTX_W     = 9
);
    localparam int ERR_W = BPP + 1;

    // update request channel
    logic                 in_valid;
    logic                 in_ready;
    logic [CTX_W-1:0]     in_ctx;
    logic                 in_mode;
    logic [ERR_W-1:0]     in_err;
    logic                 in_ritype;

    // lookup channel
    logic [CTX_W-1:0]     rd_ctx;
    logic [A_LENGTH-1:0]  rd_A;
    logic [B_LENGTH-1:0]  rd_B;
    logic [C_LENGTH-1:0]  rd_C;
    logic [N_LENGTH-1:0]  rd_N;
    logic [NN_LENGTH-1:0] rd_Nn;

    // commit channel
    logic                 upd_valid;
    logic [CTX_W-1:0]     upd_ctx;
    logic [A_LENGTH-1:0]  upd_A;
    logic [B_LENGTH-1:0]  upd_B;
    logic [C_LENGTH-1:0]  upd_C;
    logic [N_LENGTH-1:0]  upd_N;
    logic [NN_LENGTH-1:0] upd_Nn;

    // status
    logic                 busy;
    logic                 ctx_err;

    modport master (
        output in_valid, in_ctx, in_mode, in_err, in_ritype, rd_ctx,
        input  in_ready, rd_A, rd_B, rd_C, rd_N, rd_Nn,
        input  upd_valid, upd_ctx, upd_A, upd_B, upd_C, upd_N, upd_Nn,
        input  busy, ctx_err
    );

    modport slave (
        input  in_valid, in_ctx, in_mode, in_err, in_ritype, rd_ctx,
        output in_ready, rd_A, rd_B, rd_C, rd_N, rd_Nn,
        output upd_valid, upd_ctx, upd_A, upd_B, upd_C, upd_N, upd_Nn,
        output busy, ctx_err
    );
endinterface

// File: rtl/context_update_engine.sv
// Context store (A,B,C,N,Nn) with pipelined read-modify-write for regular and run-interruption updates.
// Latency: accept cycle reads the store, commit (upd_valid) on the next cycle; lookup port 1 cycle.
// Backpressure: in_ready low only while the store is being initialised; 1 update/cycle in RUN.
module context_update_engine #(
    parameter int BPP       = 8,
    parameter int A_LENGTH  = 14,
    parameter int B_LENGTH  = 8,
    parameter int C_LENGTH  = 8,
    parameter int N_LENGTH  = 7,
    parameter int NN_LENGTH = 7,
    parameter int CTX_COUNT = 367,
    parameter int CTX_W     = 9,
    parameter int RESET_THR = 64,
    parameter int A_INIT    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    context_update_engine_if.slave  bus
);
    localparam int ERR_W = BPP + 1;
    localparam int EW    = ERR_W + 1;      // room for |err| of the most negative error
    localparam int AW    = A_LENGTH + 2;   // sign bit plus carry headroom for A arithmetic
    localparam int BW    = B_LENGTH + 2;

    localparam logic signed [AW-1:0]       A_MAX = AW'((2 ** A_LENGTH) - 1);
    localparam logic signed [C_LENGTH-1:0] MIN_C = {1'b1, {(C_LENGTH-1){1'b0}}};
    localparam logic signed [C_LENGTH-1:0] MAX_C = {1'b0, {(C_LENGTH-1){1'b1}}};

    typedef struct packed {
        logic [A_LENGTH-1:0]  a;
        logic [B_LENGTH-1:0]  b;
        logic [C_LENGTH-1:0]  c;
        logic [N_LENGTH-1:0]  n;
        logic [NN_LENGTH-1:0] nn;
    } ctx_t;

    localparam ctx_t CTX_INIT = {A_LENGTH'(A_INIT), B_LENGTH'(0), C_LENGTH'(0),
                                 N_LENGTH'(1), NN_LENGTH'(0)};

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t             state_q, state_d;
    logic [CTX_W-1:0]   init_addr_q, init_addr_d;
    ctx_t               mem_q [CTX_COUNT];

    logic               s2_vld_q;
    logic [CTX_W-1:0]   s2_ctx_q;
    logic               s2_mode_q;
    logic signed [ERR_W-1:0] s2_err_q;
    logic               s2_rit_q;
    ctx_t               s2_cur_q;
    ctx_t               s2_new;
    ctx_t               rd_q;
    logic               ctx_err_q;

    logic               accept;
    logic               ctx_ok;
    logic               rd_ok;
    logic               wr_en;
    logic [CTX_W-1:0]   wr_addr;
    ctx_t               wr_dat;

    logic                       halve;
    logic signed [EW-1:0]       err_x, abs_x;
    logic signed [AW-1:0]       a_w;
    logic signed [BW-1:0]       b_w, n_s;
    logic signed [C_LENGTH-1:0] c_w;
    logic [N_LENGTH-1:0]        n_w;
    logic [NN_LENGTH-1:0]       nn_w;

    assign accept = bus.in_valid && bus.in_ready;
    assign ctx_ok = bus.in_ctx < CTX_W'(CTX_COUNT);
    assign rd_ok  = bus.rd_ctx < CTX_W'(CTX_COUNT);

    // FSM state and init address register; reset always restarts the store sweep
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_INIT;
            init_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
        end
    end

    // next state: sweep every context once, then serve updates forever
    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        bus.busy     = 1'b0;
        bus.in_ready = 1'b0;
        case (state_q)
            S_INIT: begin
                bus.busy    = 1'b1;
                init_addr_d = init_addr_q + CTX_W'(1);
                if (init_addr_q == CTX_W'(CTX_COUNT - 1)) begin
                    state_d     = S_RUN;
                    init_addr_d = '0;
                end
            end
            default: bus.in_ready = 1'b1;
        endcase
    end

    // single write port: init sweep has priority, otherwise the S2 commit
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = s2_ctx_q;
        wr_dat  = s2_new;
        if (state_q == S_INIT) begin
            wr_en   = 1'b1;
            wr_addr = init_addr_q;
            wr_dat  = CTX_INIT;
        end else if (s2_vld_q) begin
            wr_en = 1'b1;
        end
    end

    // context store array
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_dat;
    end

    // S1 capture and lookup register; both read write-first so a same-context commit is forwarded
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_vld_q  <= 1'b0;
            s2_ctx_q  <= '0;
            s2_mode_q <= 1'b0;
            s2_err_q  <= '0;
            s2_rit_q  <= 1'b0;
            s2_cur_q  <= '0;
            rd_q      <= '0;
            ctx_err_q <= 1'b0;
        end else begin
            s2_vld_q  <= accept && ctx_ok;
            ctx_err_q <= ctx_err_q | (accept & ~ctx_ok);
            if (accept) begin
                s2_ctx_q  <= bus.in_ctx;
                s2_mode_q <= bus.in_mode;
                s2_err_q  <= $signed(bus.in_err);
                s2_rit_q  <= bus.in_ritype;
                s2_cur_q  <= (wr_en && wr_addr == bus.in_ctx) ? wr_dat : mem_q[bus.in_ctx];
            end
            if (wr_en && wr_addr == bus.rd_ctx) rd_q <= wr_dat;
            else if (rd_ok)                      rd_q <= mem_q[bus.rd_ctx];
            else                                 rd_q <= '0;
        end
    end

    // S2 update arithmetic; halving decision uses the pre-update N
    always_comb begin
        s2_new = s2_cur_q;
        halve  = (s2_cur_q.n == N_LENGTH'(RESET_THR));
        err_x  = EW'(s2_err_q);
        abs_x  = err_x[EW-1] ? -err_x : err_x;
        a_w    = AW'(s2_cur_q.a) + AW'(abs_x) - AW'(s2_mode_q & s2_rit_q);
        if (a_w[AW-1]) a_w = '0;
        b_w    = BW'($signed(s2_cur_q.b)) + BW'(s2_err_q);
        nn_w   = s2_cur_q.nn + NN_LENGTH'(s2_err_q[ERR_W-1]);
        n_w    = s2_cur_q.n;
        c_w    = $signed(s2_cur_q.c);
        if (halve) begin
            a_w  = a_w >>> 1;
            b_w  = b_w >>> 1;
            nn_w = nn_w >> 1;
            n_w  = n_w >> 1;
        end
        if (a_w > A_MAX) a_w = A_MAX;
        n_w = n_w + N_LENGTH'(1);
        n_s = BW'(n_w);
        if (!s2_mode_q) begin
            // keep B in [-(N-1), 0], nudging the bias correction C one step per update
            if (b_w <= -n_s) begin
                b_w = b_w + n_s;
                if (c_w != MIN_C) c_w = c_w - C_LENGTH'(1);
                if (b_w <= -n_s) b_w = -n_s + BW'(1);
            end else if (!b_w[BW-1] && b_w != '0) begin
                b_w = b_w - n_s;
                if (c_w != MAX_C) c_w = c_w + C_LENGTH'(1);
                if (!b_w[BW-1] && b_w != '0) b_w = '0;
            end
            s2_new.b = b_w[B_LENGTH-1:0];
            s2_new.c = c_w;
        end else begin
            s2_new.nn = nn_w;
        end
        s2_new.a = a_w[A_LENGTH-1:0];
        s2_new.n = n_w;
    end

    assign bus.upd_valid = s2_vld_q;
    assign bus.upd_ctx   = s2_vld_q ? s2_ctx_q   : '0;
    assign bus.upd_A     = s2_vld_q ? s2_new.a  : '0;
    assign bus.upd_B     = s2_vld_q ? s2_new.b  : '0;
    assign bus.upd_C     = s2_vld_q ? s2_new.c  : '0;
    assign bus.upd_N     = s2_vld_q ? s2_new.n  : '0;
    assign bus.upd_Nn    = s2_vld_q ? s2_new.nn : '0;

    assign bus.rd_A      = rd_q.a;
    assign bus.rd_B      = rd_q.b;
    assign bus.rd_C      = rd_q.c;
    assign bus.rd_N      = rd_q.n;
    assign bus.rd_Nn     = rd_q.nn;
    assign bus.ctx_err   = ctx_err_q;
endmodule

// File: tb/tb_context_update_engine.sv
// Self-checking bench for context_update_engine: directed scenarios plus randomized traffic
// compared against a serial per-context model.
// Inputs driven on the falling edge, outputs sampled on the following falling edge.
module tb_context_update_engine;
    logic clk = 1'b0;
    logic reset;

    context_update_engine_if bus ();

    context_update_engine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int a;
        int b;
        int c;
        int n;
        int nn;
    } ent_t;

    localparam ent_t INIT_E = '{a: 4, b: 0, c: 0, n: 1, nn: 0};

    int   n_chk  = 0;
    int   n_fail = 0;
    ent_t model_q [367];

    function automatic void model_init();
        for (int i = 0; i < 367; i++) model_q[i] = INIT_E;
    endfunction

    function automatic int floor_half(int v);
        return (v >= 0) ? v / 2 : -((1 - v) / 2);
    endfunction

    // serial reference: one update applied in arrival order
    function automatic ent_t model_apply(int ctx, bit mode, int err, bit rit);
        ent_t e;
        bit   h;
        int   mag;
        e   = model_q[ctx];
        h   = (e.n == 64);
        mag = (err < 0) ? -err : err;
        if (!mode) begin
            e.a = e.a + mag;
            e.b = e.b + err;
            if (h) begin
                e.a = e.a / 2;
                e.b = floor_half(e.b);
                e.n = e.n / 2;
            end
            e.n = e.n + 1;
            if (e.b <= -e.n) begin
                e.b = e.b + e.n;
                if (e.c > -128) e.c = e.c - 1;
                if (e.b <= -e.n) e.b = -e.n + 1;
            end else if (e.b > 0) begin
                e.b = e.b - e.n;
                if (e.c < 127) e.c = e.c + 1;
                if (e.b > 0) e.b = 0;
            end
        end else begin
            e.a = e.a + mag - int'(rit);
            if (e.a < 0) e.a = 0;
            e.nn = e.nn + ((err < 0) ? 1 : 0);
            if (h) begin
                e.a  = e.a / 2;
                e.nn = e.nn / 2;
                e.n  = e.n / 2;
            end
            e.n = e.n + 1;
        end
        if (e.a > 16383) e.a = 16383;
        model_q[ctx] = e;
        return e;
    endfunction

    function automatic ent_t obs_upd();
        return '{a: int'(bus.upd_A), b: int'($signed(bus.upd_B)), c: int'($signed(bus.upd_C)),
                 n: int'(bus.upd_N), nn: int'(bus.upd_Nn)};
    endfunction

    function automatic ent_t obs_rd();
        return '{a: int'(bus.rd_A), b: int'($signed(bus.rd_B)), c: int'($signed(bus.rd_C)),
                 n: int'(bus.rd_N), nn: int'(bus.rd_Nn)};
    endfunction

    task automatic drive(bit v, int ctx, bit mode, int err, bit rit);
        bus.in_valid  = v;
        bus.in_ctx    = 9'(ctx);
        bus.in_mode   = mode;
        bus.in_err    = 9'(err);
        bus.in_ritype = rit;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    // count falling edges with busy high, starting right at reset release
    task automatic wait_init(input string tag);
        int cnt;
        cnt = 0;
        while (bus.busy && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        n_chk++;
        if (cnt !== 367) begin
            n_fail++;
            $display("FAIL %s busy_cycles: got %0d expected 367", tag, cnt);
        end
    endtask

    task automatic test_reset();
        ent_t o;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        bus.rd_ctx = '0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (bus.in_ready !== 1'b0 || bus.upd_valid !== 1'b0 || bus.ctx_err !== 1'b0 || bus.rd_A !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b uv=%b err=%b rdA=%0d expected 0 0 0 0",
                     bus.in_ready, bus.upd_valid, bus.ctx_err, bus.rd_A);
        end
        reset = 1'b0;
        wait_init("reset");
        model_init();
        bus.rd_ctx = 9'd0;
        @(negedge clk);
        o = obs_rd();
        n_chk++;
        if (o !== INIT_E) begin
            n_fail++;
            $display("FAIL init_ctx0: got A=%0d B=%0d C=%0d N=%0d Nn=%0d expected 4 0 0 1 0", o.a, o.b, o.c, o.n, o.nn);
        end
        bus.rd_ctx = 9'd366;
        @(negedge clk);
        o = obs_rd();
        n_chk++;
        if (o !== INIT_E) begin
            n_fail++;
            $display("FAIL init_ctx366: got A=%0d B=%0d C=%0d N=%0d Nn=%0d expected 4 0 0 1 0", o.a, o.b, o.c, o.n, o.nn);
        end
    endtask

    task automatic test_mode0_basic();
        ent_t o;
        ent_t want;
        want = '{a: 7, b: 0, c: 1, n: 2, nn: 0};
        drive(1, 5, 0, 3, 0);
        void'(model_apply(5, 0, 3, 0));
        @(negedge clk);
        idle();
        o = obs_upd();
        n_chk++;
        if (bus.upd_valid !== 1'b1 || bus.upd_ctx !== 9'd5 || o !== want) begin
            n_fail++;
            $display("FAIL mode0_ctx5: got v=%b ctx=%0d A=%0d B=%0d C=%0d N=%0d Nn=%0d expected 1 5 7 0 1 2 0",
                     bus.upd_valid, bus.upd_ctx, o.a, o.b, o.c, o.n, o.nn);
        end
        @(negedge clk);
        n_chk++;
        if (bus.upd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mode0_single_pulse: got upd_valid=%b expected 0", bus.upd_valid);
        end
    endtask

    task automatic test_halving();
        ent_t o;
        ent_t want_pre;
        ent_t want;
        want_pre = '{a: 14, b: -10, c: 0, n: 64, nn: 0};
        want     = '{a: 8,  b: -6,  c: 0, n: 33, nn: 0};
        for (int i = 0; i < 62; i++) begin
            drive(1, 9, 0, 0, 0);
            void'(model_apply(9, 0, 0, 0));
            @(negedge clk);
        end
        drive(1, 9, 0, -10, 0);
        void'(model_apply(9, 0, -10, 0));
        @(negedge clk);
        o = obs_upd();
        drive(1, 9, 0, -2, 0);
        void'(model_apply(9, 0, -2, 0));
        n_chk++;
        if (o !== want_pre) begin
            n_fail++;
            $display("FAIL reach_thr: got A=%0d B=%0d C=%0d N=%0d expected 14 -10 0 64", o.a, o.b, o.c, o.n);
        end
        @(negedge clk);
        idle();
        o = obs_upd();
        n_chk++;
        if (o !== want) begin
            n_fail++;
            $display("FAIL halving: got A=%0d B=%0d C=%0d N=%0d Nn=%0d expected 8 -6 0 33 0", o.a, o.b, o.c, o.n, o.nn);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        ent_t o;
        ent_t want [3];
        want[0] = '{a: 9,  b: -1, c: -1, n: 2, nn: 0};
        want[1] = '{a: 14, b: -2, c: -2, n: 3, nn: 0};
        want[2] = '{a: 19, b: -3, c: -3, n: 4, nn: 0};
        drive(1, 7, 0, -5, 0);
        void'(model_apply(7, 0, -5, 0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            o = obs_upd();
            if (k < 2) begin
                drive(1, 7, 0, -5, 0);
                void'(model_apply(7, 0, -5, 0));
            end else begin
                idle();
            end
            n_chk++;
            if (bus.upd_valid !== 1'b1 || o !== want[k]) begin
                n_fail++;
                $display("FAIL b2b_%0d: got v=%b A=%0d B=%0d C=%0d N=%0d expected 1 %0d %0d %0d %0d",
                         k, bus.upd_valid, o.a, o.b, o.c, o.n, want[k].a, want[k].b, want[k].c, want[k].n);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_mode1();
        ent_t o;
        ent_t want;
        want = '{a: 7, b: 0, c: 0, n: 2, nn: 1};
        drive(1, 365, 1, -4, 1);
        void'(model_apply(365, 1, -4, 1));
        @(negedge clk);
        idle();
        o = obs_upd();
        n_chk++;
        if (bus.upd_valid !== 1'b1 || bus.upd_ctx !== 9'd365 || o !== want) begin
            n_fail++;
            $display("FAIL mode1_ctx365: got v=%b ctx=%0d A=%0d B=%0d C=%0d N=%0d Nn=%0d expected 1 365 7 0 0 2 1",
                     bus.upd_valid, bus.upd_ctx, o.a, o.b, o.c, o.n, o.nn);
        end
        @(negedge clk);
    endtask

    task automatic test_lookup_write_first();
        ent_t o;
        ent_t e;
        drive(1, 7, 0, 6, 0);
        e = model_apply(7, 0, 6, 0);
        @(negedge clk);
        idle();
        bus.rd_ctx = 9'd7;
        @(negedge clk);
        o = obs_rd();
        n_chk++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL lookup_write_first: got A=%0d B=%0d C=%0d N=%0d Nn=%0d expected %0d %0d %0d %0d %0d",
                     o.a, o.b, o.c, o.n, o.nn, e.a, e.b, e.c, e.n, e.nn);
        end
    endtask

    task automatic test_random();
        ent_t o;
        ent_t e;
        bit   v, mode, rit;
        int   ctx, err;
        for (int i = 0; i < 600; i++) begin
            v    = ($urandom_range(0, 3) != 0);
            ctx  = ($urandom_range(0, 4) == 0) ? 365 + int'($urandom_range(0, 1)) : int'($urandom_range(0, 3));
            mode = (ctx >= 365) ? 1'b1 : ($urandom_range(0, 7) == 0);
            err  = int'($urandom_range(0, 255)) - 128;
            rit  = 1'($urandom_range(0, 1));
            drive(v, ctx, mode, err, rit);
            if (v) e = model_apply(ctx, mode, err, rit);
            @(negedge clk);
            o = obs_upd();
            n_chk++;
            if (bus.upd_valid !== v) begin
                n_fail++;
                $display("FAIL rand_valid[%0d]: got %b expected %b", i, bus.upd_valid, v);
            end else if (v) begin
                n_chk++;
                if (bus.upd_ctx !== 9'(ctx) || o !== e) begin
                    n_fail++;
                    $display("FAIL rand_upd[%0d]: got ctx=%0d A=%0d B=%0d C=%0d N=%0d Nn=%0d expected %0d %0d %0d %0d %0d %0d",
                             i, bus.upd_ctx, o.a, o.b, o.c, o.n, o.nn, ctx, e.a, e.b, e.c, e.n, e.nn);
                end
            end
        end
        idle();
        @(negedge clk);
    endtask

    task automatic test_out_of_range();
        drive(1, 400, 0, 3, 0);
        @(negedge clk);
        idle();
        n_chk++;
        if (bus.upd_valid !== 1'b0 || bus.ctx_err !== 1'b1) begin
            n_fail++;
            $display("FAIL out_of_range: got upd_valid=%b ctx_err=%b expected 0 1", bus.upd_valid, bus.ctx_err);
        end
        repeat (2) @(negedge clk);
        n_chk++;
        if (bus.ctx_err !== 1'b1 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ctx_err_sticky: got ctx_err=%b in_ready=%b expected 1 1", bus.ctx_err, bus.in_ready);
        end
    endtask

    task automatic test_reset_midstream();
        ent_t o;
        drive(1, 2, 0, 5, 0);
        @(posedge clk);
        #2 reset = 1'b1;
        idle();
        #1;
        n_chk++;
        if (bus.ctx_err !== 1'b0 || bus.busy !== 1'b1 || bus.upd_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got ctx_err=%b busy=%b upd_valid=%b in_ready=%b expected 0 1 0 0",
                     bus.ctx_err, bus.busy, bus.upd_valid, bus.in_ready);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_init("mid_reset");
        model_init();
        bus.rd_ctx = 9'd7;
        @(negedge clk);
        o = obs_rd();
        n_chk++;
        if (o !== INIT_E) begin
            n_fail++;
            $display("FAIL reinit_ctx7: got A=%0d B=%0d C=%0d N=%0d Nn=%0d expected 4 0 0 1 0", o.a, o.b, o.c, o.n, o.nn);
        end
        bus.rd_ctx = 9'd2;
        @(negedge clk);
        o = obs_rd();
        n_chk++;
        if (o !== INIT_E) begin
            n_fail++;
            $display("FAIL reinit_ctx2: got A=%0d B=%0d C=%0d N=%0d Nn=%0d expected 4 0 0 1 0", o.a, o.b, o.c, o.n, o.nn);
        end
    endtask

    initial begin
        test_reset();
        test_mode0_basic();
        test_halving();
        test_back_to_back();
        test_mode1();
        test_lookup_write_first();
        test_random();
        test_out_of_range();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end
endmodule
